// File: rtl/slice_component_scheduler.sv
// Slice component scheduler: runs one slice through the shared component
// encoder in the order Y, Cb, Cr using a done handshake per component and
// a watchdog that bounds each component run.
`timescale 1ns/1ps
module slice_component_scheduler #(
  parameter logic [31:0] Y_OFFSET    = 32'd0,
  parameter logic [31:0] CB_OFFSET   = 32'd2048,
  parameter logic [31:0] CR_OFFSET   = 32'd3072,
  parameter logic [31:0] Y_BLOCK_NUM = 32'd32,
  parameter logic [31:0] C_BLOCK_NUM = 32'd16,
  parameter logic [31:0] TIMEOUT     = 32'd3000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        slice_start,
  input  logic        component_done,
  input  logic [31:0] set_bit_total_byte_size,
  output logic        component_reset_n,
  output logic [31:0] offset,
  output logic [31:0] block_num,
  output logic        is_y,
  output logic [31:0] y_size,
  output logic [31:0] cb_size,
  output logic [31:0] cr_size,
  output logic        slice_busy,
  output logic        slice_done,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    Y_RST  = 3'd1,
    Y_RUN  = 3'd2,
    CB_RST = 3'd3,
    CB_RUN = 3'd4,
    CR_RST = 3'd5,
    CR_RUN = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic        comp_rst_n_q, comp_rst_n_d;
  logic [31:0] offset_q, offset_d;
  logic [31:0] block_num_q, block_num_d;
  logic        is_y_q, is_y_d;
  logic [31:0] y_size_q, y_size_d;
  logic [31:0] cb_size_q, cb_size_d;
  logic [31:0] cr_size_q, cr_size_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        terr_q, terr_d;
  logic [31:0] timer_q, timer_d;

  logic        timer_expired_s;
  logic        run_exit_s;
  logic        run_timeout_s;

  // Watchdog decode: a run ends on done or on the last allowed cycle; done wins.
  always_comb begin
    timer_expired_s = (timer_q == (TIMEOUT - 32'd1));
    run_exit_s      = component_done | timer_expired_s;
    run_timeout_s   = (~component_done) & timer_expired_s;
  end

  // Next-state and registered-output computation for the slice sequencer.
  always_comb begin
    state_d      = state_q;
    comp_rst_n_d = comp_rst_n_q;
    offset_d     = offset_q;
    block_num_d  = block_num_q;
    is_y_d       = is_y_q;
    y_size_d     = y_size_q;
    cb_size_d    = cb_size_q;
    cr_size_d    = cr_size_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    terr_d       = terr_q;
    timer_d      = timer_q;
    case (state_q)
      IDLE: begin
        if (slice_start) begin
          state_d     = Y_RST;
          offset_d    = Y_OFFSET;
          block_num_d = Y_BLOCK_NUM;
          is_y_d      = 1'b1;
          y_size_d    = 32'd0;
          cb_size_d   = 32'd0;
          cr_size_d   = 32'd0;
          terr_d      = 1'b0;
          busy_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      Y_RST, CB_RST, CR_RST: begin
        // Encoder has been held in reset for one cycle; release it and arm the watchdog.
        state_d      = state_t'(state_q + 3'd1);
        comp_rst_n_d = 1'b1;
        timer_d      = 32'd0;
      end
      Y_RUN: begin
        if (run_exit_s) begin
          y_size_d     = set_bit_total_byte_size;
          terr_d       = terr_q | run_timeout_s;
          comp_rst_n_d = 1'b0;
          state_d      = CB_RST;
          offset_d     = CB_OFFSET;
          block_num_d  = C_BLOCK_NUM;
          is_y_d       = 1'b0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      CB_RUN: begin
        if (run_exit_s) begin
          cb_size_d    = set_bit_total_byte_size;
          terr_d       = terr_q | run_timeout_s;
          comp_rst_n_d = 1'b0;
          state_d      = CR_RST;
          offset_d     = CR_OFFSET;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      CR_RUN: begin
        if (run_exit_s) begin
          cr_size_d    = set_bit_total_byte_size;
          terr_d       = terr_q | run_timeout_s;
          comp_rst_n_d = 1'b0;
          state_d      = DONE;
          done_d       = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d      = IDLE;
        comp_rst_n_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      comp_rst_n_q <= 1'b0;
      offset_q     <= Y_OFFSET;
      block_num_q  <= Y_BLOCK_NUM;
      is_y_q       <= 1'b1;
      y_size_q     <= 32'd0;
      cb_size_q    <= 32'd0;
      cr_size_q    <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      terr_q       <= 1'b0;
      timer_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      comp_rst_n_q <= comp_rst_n_d;
      offset_q     <= offset_d;
      block_num_q  <= block_num_d;
      is_y_q       <= is_y_d;
      y_size_q     <= y_size_d;
      cb_size_q    <= cb_size_d;
      cr_size_q    <= cr_size_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      terr_q       <= terr_d;
      timer_q      <= timer_d;
    end
  end

  assign component_reset_n = comp_rst_n_q;
  assign offset            = offset_q;
  assign block_num         = block_num_q;
  assign is_y              = is_y_q;
  assign y_size            = y_size_q;
  assign cb_size           = cb_size_q;
  assign cr_size           = cr_size_q;
  assign slice_busy        = busy_q;
  assign slice_done        = done_q;
  assign timeout_err       = terr_q;

endmodule

// File: tb/tb_slice_component_scheduler.sv
// Bench for slice_component_scheduler: table-driven slices, random slices
// against a behavioural model, and hand-written latency / reset sequences.
`timescale 1ns/1ps
module tb_slice_component_scheduler;

  localparam int TIMEOUT = 3000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        slice_start = 1'b0;
  logic        component_done = 1'b0;
  logic [31:0] set_bit_total_byte_size = 32'd0;
  logic        component_reset_n;
  logic [31:0] offset, block_num, y_size, cb_size, cr_size;
  logic        is_y, slice_busy, slice_done, timeout_err;

  int n_vec = 0;
  int n_err = 0;

  slice_component_scheduler dut (
    .clock(clock), .reset(reset), .slice_start(slice_start),
    .component_done(component_done), .set_bit_total_byte_size(set_bit_total_byte_size),
    .component_reset_n(component_reset_n), .offset(offset), .block_num(block_num),
    .is_y(is_y), .y_size(y_size), .cb_size(cb_size), .cr_size(cr_size),
    .slice_busy(slice_busy), .slice_done(slice_done), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0][31:0] k;    // cycles after encoder release before done (>= TIMEOUT: never)
    logic [2:0][31:0] sz;   // byte size presented on the bus for each component
    bit               extra;
    logic [31:0]      exp_y, exp_cb, exp_cr;
    bit               exp_terr;
  } vec_t;

  vec_t tbl [4];

  function automatic vec_t mk(input int k0, input int k1, input int k2,
                              input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                              input bit extra, input logic [31:0] ey, input logic [31:0] ecb,
                              input logic [31:0] ecr, input bit eterr);
    vec_t v;
    v.k[0] = k0; v.k[1] = k1; v.k[2] = k2;
    v.sz[0] = s0; v.sz[1] = s1; v.sz[2] = s2;
    v.extra = extra;
    v.exp_y = ey; v.exp_cb = ecb; v.exp_cr = ecr; v.exp_terr = eterr;
    return v;
  endfunction

  // Reference model: a component run lasts until done is seen, capped at TIMEOUT cycles.
  function automatic int exp_run_len(input logic [31:0] k);
    if (k < TIMEOUT) return int'(k) + 1;
    else return TIMEOUT;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_rise(output bit ok);
    int w;
    w = 0;
    while (!component_reset_n && w < 20) begin
      @(negedge clock);
      w++;
    end
    ok = component_reset_n;
    check("rst_n_rise_bound", {31'd0, ok}, 32'd1);
  endtask

  task automatic run_component(input int idx, input logic [31:0] k, input logic [31:0] size,
                               input bit extra, output int run_len);
    bit ok;
    int cnt;
    logic [31:0] e_off, e_blk;
    run_len = 0;
    wait_rise(ok);
    if (!ok) return;
    e_off = (idx == 0) ? 32'd0 : (idx == 1) ? 32'd2048 : 32'd3072;
    e_blk = (idx == 0) ? 32'd32 : 32'd16;
    check("offset", offset, e_off);
    check("block_num", block_num, e_blk);
    check("is_y", {31'd0, is_y}, (idx == 0) ? 32'd1 : 32'd0);
    check("busy_in_run", {31'd0, slice_busy}, 32'd1);
    set_bit_total_byte_size = size;
    cnt = 0;
    while (component_reset_n && cnt < TIMEOUT + 5) begin
      component_done = (cnt == int'(k));
      slice_start    = extra && (cnt == 1);
      @(negedge clock);
      cnt++;
    end
    component_done = 1'b0;
    slice_start    = 1'b0;
    run_len = cnt;
    check("run_len", run_len, exp_run_len(k));
  endtask

  task automatic run_slice(input vec_t v);
    int len;
    @(negedge clock); slice_start = 1'b1;
    @(negedge clock); slice_start = 1'b0;
    check("busy_after_start", {31'd0, slice_busy}, 32'd1);
    check("terr_cleared", {31'd0, timeout_err}, 32'd0);
    check("y_cleared", y_size, 32'd0);
    for (int i = 0; i < 3; i++) run_component(i, v.k[i], v.sz[i], v.extra && i == 0, len);
    check("slice_done", {31'd0, slice_done}, 32'd1);
    check("busy_in_done", {31'd0, slice_busy}, 32'd1);
    check("y_size", y_size, v.exp_y);
    check("cb_size", cb_size, v.exp_cb);
    check("cr_size", cr_size, v.exp_cr);
    check("timeout_err", {31'd0, timeout_err}, {31'd0, v.exp_terr});
    @(negedge clock);
    check("slice_done_low", {31'd0, slice_done}, 32'd0);
    check("busy_low", {31'd0, slice_busy}, 32'd0);
    check("offset_hold", offset, 32'd3072);
    check("is_y_hold", {31'd0, is_y}, 32'd0);
    check("terr_hold", {31'd0, timeout_err}, {31'd0, v.exp_terr});
  endtask

  task automatic check_reset_values();
    check("rst_comp_rst_n", {31'd0, component_reset_n}, 32'd0);
    check("rst_offset", offset, 32'd0);
    check("rst_block_num", block_num, 32'd32);
    check("rst_is_y", {31'd0, is_y}, 32'd1);
    check("rst_y", y_size, 32'd0);
    check("rst_cb", cb_size, 32'd0);
    check("rst_cr", cr_size, 32'd0);
    check("rst_busy", {31'd0, slice_busy}, 32'd0);
    check("rst_done", {31'd0, slice_done}, 32'd0);
    check("rst_terr", {31'd0, timeout_err}, 32'd0);
  endtask

  initial begin
    vec_t rv;
    int first_done, first_idle, n_pulses, len, to_budget;
    bit ok, any_to;

    tbl[0] = mk(5, 5, 5, 32'd1000, 32'd400, 32'd380, 1'b0, 32'd1000, 32'd400, 32'd380, 1'b0);
    tbl[1] = mk(0, TIMEOUT + 100, 3, 32'd11, 32'd22, 32'd33, 1'b0, 32'd11, 32'd22, 32'd33, 1'b1);
    tbl[2] = mk(2, TIMEOUT - 1, 1, 32'd7, 32'd8, 32'd9, 1'b0, 32'd7, 32'd8, 32'd9, 1'b0);
    tbl[3] = mk(4, 1, 2, 32'hDEADBEEF, 32'd5, 32'd6, 1'b1, 32'hDEADBEEF, 32'd5, 32'd6, 1'b0);

    // Reset, then idle
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check_reset_values();

    for (int i = 0; i < 4; i++) run_slice(tbl[i]);

    // done held high from start: minimum latency
    component_done = 1'b1;
    set_bit_total_byte_size = 32'd77;
    @(negedge clock); slice_start = 1'b1;
    first_done = 0; first_idle = 0; n_pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      slice_start = 1'b0;
      if (slice_done) n_pulses++;
      if (slice_done && first_done == 0) first_done = c;
      if (!slice_busy && first_idle == 0) first_idle = c;
    end
    component_done = 1'b0;
    check("min_lat_done", first_done, 32'd7);
    check("min_lat_idle", first_idle, 32'd8);
    check("min_lat_pulses", n_pulses, 32'd1);
    check("min_lat_y", y_size, 32'd77);
    check("min_lat_cr", cr_size, 32'd77);
    check("min_lat_busy_end", {31'd0, slice_busy}, 32'd0);

    // Reset asserted during Cr run aborts the slice
    @(negedge clock); slice_start = 1'b1;
    @(negedge clock); slice_start = 1'b0;
    run_component(0, 32'd3, 32'd55, 1'b1, len);
    run_component(1, 32'd2, 32'd66, 1'b0, len);
    wait_rise(ok);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_values();
    n_pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (slice_done) n_pulses++;
    end
    check("abort_no_done", n_pulses, 32'd0);
    run_slice(tbl[0]);

    // Random slices against the model
    to_budget = 2;
    for (int n = 0; n < 20; n++) begin
      any_to = 1'b0;
      for (int i = 0; i < 3; i++) begin
        rv.k[i] = $urandom_range(0, 12);
        if (to_budget > 0 && $urandom_range(0, 9) == 0) begin
          rv.k[i] = TIMEOUT + 7;
          to_budget--;
        end
        rv.sz[i] = $urandom;
        if (rv.k[i] >= TIMEOUT) any_to = 1'b1;
      end
      rv.extra = ($urandom_range(0, 3) == 0) && (rv.k[0] > 1);
      rv.exp_y = rv.sz[0]; rv.exp_cb = rv.sz[1]; rv.exp_cr = rv.sz[2];
      rv.exp_terr = any_to;
      run_slice(rv);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
